// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential word fetches, in-order responses buffered with their PCs.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects are ignored and flagged (sticky).
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW:0]   out_q, out_d;
    logic [AW:0]   drop_q, drop_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   tag_wr_q, tag_rd_q;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];

    logic          redir, fire, rsp, push, pop;
    logic [AW:0]   occ, remain;
    logic [AW+1:0] credit_used;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign redir = redirect_valid && (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign redir          = redirect_valid;
    assign fetch_misalign = 1'b0;
`endif

    // Credit rule: in-flight requests plus buffered entries never exceed DEPTH.
    assign occ            = wr_q - rd_q;
    assign credit_used    = {1'b0, out_q} + {1'b0, occ};
    assign imem_req_valid = !reset && (state_q == StFetch) && !redirect_valid
                            && (credit_used < (AW+2)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;
    assign rsp            = imem_rsp_valid && (out_q != '0);
    assign push           = rsp && (state_q == StFetch) && !redir;
    assign id_valid       = (wr_q != rd_q);
    assign pop            = id_valid && id_ready && !redir;
    assign id_inst        = id_valid ? inst_mem[rd_q[AW-1:0]] : 32'h0;
    assign id_pc          = id_valid ? pc_mem[rd_q[AW-1:0]] : 32'h0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        wr_d    = wr_q + (AW+1)'(push);
        rd_d    = rd_q + (AW+1)'(pop);
        out_d   = out_q + (AW+1)'(fire) - (AW+1)'(rsp);
        remain  = '0;
        if (fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (redir) begin
            // No fire is possible during a redirect, so out_q is exact here.
            remain  = (state_q == StFetch) ? out_q - (AW+1)'(rsp) : drop_q - (AW+1)'(rsp);
            pc_d    = redirect_pc & ~32'h3;
            wr_d    = '0;
            rd_d    = '0;
            drop_d  = remain;
            state_d = (remain != '0) ? StDrain : StFetch;
        end else if ((state_q == StDrain) && rsp) begin
            drop_d = drop_q - (AW+1)'(1);
            if (drop_q == (AW+1)'(1)) begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            tag_wr_q <= tag_wr_q + (AW+1)'(fire);
            tag_rd_q <= tag_rd_q + (AW+1)'(rsp);
        end
    end

    // Tag FIFO pops on every response, dropped or not, so it stays aligned with memory order.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[tag_wr_q[AW-1:0]] <= pc_q;
        end
        if (push) begin
            inst_mem[wr_q[AW-1:0]] <= imem_rsp_data;
            pc_mem[wr_q[AW-1:0]]   <= tag_mem[tag_rd_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised self-checking bench for fetch_queue against a queue-level reference model,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model: buffered entries, PCs of requests in flight, responses still to drop.
    ent_t        m_q[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc;
    int          m_drop;
    logic        m_mis;

    logic [31:0] mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] inst_log[$];
    int          idv_cnt  = 0;
    int          n_checks = 0;
    int          n_err    = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pend.delete();
        m_pc   = RESET_PC;
        m_drop = 0;
        m_mis  = 1'b0;
    endfunction

    always @(negedge clk) begin : mon
        logic        exp_rv, bad, hon, fire, pop;
        logic [31:0] p;
        ent_t        e;
        if (reset) model_reset();
        exp_rv = !reset && (m_drop == 0) && (m_pend.size() + m_q.size() < int'(DEPTH))
                 && !redirect_valid;
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
        check("id_inst", id_inst, (m_q.size() != 0) ? m_q[0].inst : 32'h0);
        check("id_pc", id_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
        check("misalign", 32'(fetch_misalign), 32'(m_mis));
        if (id_valid) idv_cnt++;

        if (imem_rsp_valid && (mem_q.size() != 0)) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
        end

        if (!reset) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
            bad = 1'b0;
`endif
            hon  = redirect_valid && !bad;
            pop  = (m_q.size() != 0) && id_ready && !hon;
            fire = exp_rv && imem_req_ready;
            if (bad) m_mis = 1'b1;
            if (id_valid && id_ready && !hon) begin
                pop_log.push_back(id_pc);
                inst_log.push_back(id_inst);
            end
            if (pop) void'(m_q.pop_front());
            if (imem_rsp_valid && (m_pend.size() != 0)) begin
                p = m_pend.pop_front();
                if (m_drop > 0) begin
                    m_drop--;
                end else if (!hon) begin
                    e.pc   = p;
                    e.inst = imem_rsp_data;
                    m_q.push_back(e);
                end
            end
            if (fire) begin
                m_pend.push_back(m_pc);
                m_pc += 32'd4;
            end
            if (hon) begin
                m_q.delete();
                m_pc   = redirect_pc & ~32'h3;
                m_drop = m_pend.size();
            end
        end
    end

    task automatic cycle(input bit rdy, input bit rsp_en, input bit idr, input bit rv,
                         input logic [31:0] rpc);
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rsp_en && (mem_q.size() != 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_q.delete();
        req_log.delete();
        pop_log.delete();
        inst_log.delete();
        idv_cnt = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_misalign", 32'(fetch_misalign), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;

        // Streaming with one-cycle memory: no gaps once the pipe fills.
        do_reset();
        repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stream_reqs", req_log.size(), 20);
        check("stream_pops", pop_log.size(), 18);
        check("stream_idv_cycles", idv_cnt, 18);
        check("stream_addr0", at(req_log, 0), 32'h0);
        check("stream_addr1", at(req_log, 1), 32'h4);
        check("stream_addr2", at(req_log, 2), 32'h8);
        check("stream_pc0", at(pop_log, 0), 32'h0);
        check("stream_pc2", at(pop_log, 2), 32'h8);
        check("stream_inst1", at(inst_log, 1), inst_of(32'h4));

        // Decode stalled: credit limit caps requests at DEPTH.
        do_reset();
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("stall_reqs", req_log.size(), 4);
        check("stall_id_valid", 32'(id_valid), 32'h1);
        repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_pop0", at(pop_log, 0), 32'h0);
        check("stall_pop1", at(pop_log, 1), 32'h4);
        check("stall_pop2", at(pop_log, 2), 32'h8);
        check("stall_pop3", at(pop_log, 3), 32'hC);
        check("stall_resume", at(req_log, 4), 32'h10);

        // Redirect with two responses in flight.
        do_reset();
        repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        check("drain_id_valid", 32'(id_valid), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("drain_no_req", 32'(imem_req_valid), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("drain_done_req", 32'(imem_req_valid), 32'h1);
        check("drain_done_addr", imem_req_addr, 32'h100);
        repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("drain_req4", at(req_log, 4), 32'h100);
        check("drain_pop2", at(pop_log, 2), 32'h100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        check("coinc_flushed", 32'(id_valid), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("coinc_req", 32'(imem_req_valid), 32'h1);
        check("coinc_addr", imem_req_addr, 32'h200);
        repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("coinc_req4", at(req_log, 4), 32'h200);
        check("coinc_pop0", at(pop_log, 0), 32'h200);

        // Misaligned redirect target.
        do_reset();
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
        repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_seq_req", at(req_log, 3), 32'hC);
        check("mis_pop2", at(pop_log, 2), 32'h8);
        check("mis_flag", 32'(fetch_misalign), 32'h1);
`else
        check("mis_req", at(req_log, 3), 32'h100);
        check("mis_flag", 32'(fetch_misalign), 32'h0);
`endif

        // Reset with three responses outstanding.
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_mid_id_valid", 32'(id_valid), 32'h0);
        check("rst_mid_req", 32'(imem_req_valid), 32'h1);
        check("rst_mid_addr", imem_req_addr, RESET_PC);
        repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_mid_req0", at(req_log, 0), RESET_PC);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rpc = 32'($urandom_range(0, 4095));
                if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 2) != 0), ($urandom_range(0, 22) == 0), rpc);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
